imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage. Takes a full 32-bit RISC-V instruction and an immediate-type select, produces the sign- or zero-extended immediate at XLEN bits, and delivers it through a valid/ready handshake with a two-entry skid buffer. It sits between the instruction register and the execute-stage operand mux. It replaces the single-cycle four-type extender with eight types, RV32/RV64 width, backpressure and flush.

## Interface
- XLEN, default 32: output immediate width. Legal values are 32 and 64 only.
- clk  in  1  clock; all state updates on rising edge.
- arst  in  1  asynchronous reset, active-high.
- i_flush  in  1  synchronous flush; empties the buffer.
- i_valid  in  1  upstream has an instruction.
- o_ready  out  1  block can accept; equals (state != TWO).
- i_instr  in  32  instruction word.
- i_imm_src  in  3  immediate type: 000 I, 001 S, 010 B, 011 J, 100 U, 101 SHAMT, 110 ZIMM, 111 illegal.
- o_valid  out  1  output entry present; equals (state != EMPTY).
- i_ready  in  1  downstream accepts.
- o_imm_ext  out  XLEN  extended immediate of head entry.
- o_imm_src  out  3  i_imm_src captured with the head entry.
- o_err  out  1  head entry had i_imm_src = 111.

## Operation
- Handshake events:
  - accept = i_valid & o_ready.
  - fire = o_valid & i_ready.
- Immediate formation is combinational on i_instr and is registered at accept. "sext" means sign-extend from instr[31] to XLEN.
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - U: sext({instr[31:12], 12'b0}). At XLEN=64, bits 63:32 equal instr[31].
  - SHAMT: zero-extended instr[24:20] at XLEN=32; instr[25:20] at XLEN=64.
  - ZIMM: zero-extended instr[19:15] (CSR immediate).
  - 111: immediate = 0, err = 1. The entry is still queued and delivered in order.
- Storage: a head register (drives outputs) and a skid register. Each entry holds imm, src and err.
- State machine: EMPTY, ONE, TWO.
  - EMPTY: accept -> ONE; head <= new.
  - ONE:
    - accept & !fire -> TWO; skid <= new.
    - fire & !accept -> EMPTY.
    - accept & fire -> ONE; head <= new.
    - Neither -> hold.
  - TWO: accept is impossible (o_ready = 0). fire -> ONE; head <= skid. Otherwise hold.
- i_flush has priority over accept and fire. Next state is EMPTY and data registers are don't-care. A fire coinciding with flush counts as consumed downstream. An upstream accept in the flush cycle is dropped.
- Order is strictly FIFO; no entry is duplicated or lost except by flush.
- Outputs hold stable while o_valid & !i_ready.
- When o_valid = 0, o_imm_ext, o_imm_src and o_err are 0. Outputs are gated by state, not by stale registers.

## Timing
- Reset (arst high, asynchronous): state = EMPTY; head and skid cleared. Hence o_valid = 0, o_ready = 1, o_imm_ext = 0, o_imm_src = 0, o_err = 0.
- The block operates on the first rising edge after arst deasserts.
- arst mid-operation discards all entries immediately, without waiting for a clock.
- Latency: accept at edge N gives o_valid = 1 in the cycle after edge N, with that entry at head.
- Throughput: 1 entry/cycle while i_ready = 1.
- o_ready and o_valid are decoded from registered state only. There is no combinational path from i_valid or i_ready to o_ready or o_valid.
- Full condition: o_ready drops the cycle after the second unconsumed accept. It rises the cycle after the fire that drains TWO.

## Test plan
- I type, XLEN=32: i_instr=0xFFF00093, src=000 -> one cycle later o_valid=1, o_imm_ext=0xFFFFFFFF, o_err=0.
- Back-to-back with i_ready=1:
  - S: 0xFE20AE23 -> 0xFFFFFFFC.
  - B: 0xFE000EE3 -> 0xFFFFFFFC.
  - J: 0xFF9FF06F -> 0xFFFFFFF8.
  - Required: delivered on three consecutive cycles, in order.
- XLEN=64:
  - U 0x800000B7 -> 0xFFFFFFFF80000000.
  - SHAMT 0x03F09093 -> 0x000000000000003F.
  - ZIMM with instr[19:15]=31 -> 0x1F.
  - src=111 -> imm 0, o_err=1.
- Backpressure: hold i_ready=0 and offer 3 entries -> o_ready=0 after 2 accepts, third held. Then set i_ready=1 -> three entries drain in order, o_ready=1 again the cycle after the TWO->ONE fire.
- Flush and reset:
  - In state TWO, assert i_flush with i_valid=1 -> next cycle o_valid=0, o_ready=1, offered entry dropped.
  - Assert arst asynchronously mid-stream -> o_valid=0 and o_imm_ext=0 immediately, without waiting for a clock edge.
- Simultaneous events in state ONE: accept and fire in the same cycle -> stays ONE, head replaced by the new entry, no loss.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: extracts and extends the RV immediate for eight formats
// and delivers it through a valid/ready interface backed by a two-entry skid buffer.
module imm_gen_pipe #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  input  logic [2:0]      i_imm_src,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_imm_ext,
  output logic [2:0]      o_imm_src,
  output logic            o_err
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e state_q, state_d;

  logic [XLEN-1:0] head_imm_q, skid_imm_q;
  logic [2:0]      head_src_q, skid_src_q;
  logic            head_err_q, skid_err_q;

  logic [XLEN-1:0] new_imm;
  logic            new_err;
  logic            accept, fire;
  logic            head_load, head_from_skid, skid_load;

  // Opcode bits never contribute to any immediate format.
  logic unused_opcode;
  assign unused_opcode = ^i_instr[6:0];

  always_comb begin
    new_imm = '0;
    new_err = 1'b0;
    unique case (i_imm_src)
      3'b000: new_imm = XLEN'($signed(i_instr[31:20]));
      3'b001: new_imm = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
      3'b010: new_imm = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25],
                                         i_instr[11:8], 1'b0}));
      3'b011: new_imm = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20],
                                         i_instr[30:21], 1'b0}));
      3'b100: new_imm = XLEN'($signed({i_instr[31:12], 12'b0}));
      3'b101: begin
        if (XLEN == 64) new_imm = XLEN'(i_instr[25:20]);
        else            new_imm = XLEN'(i_instr[24:20]);
      end
      3'b110: new_imm = XLEN'(i_instr[19:15]);
      default: new_err = 1'b1;
    endcase
  end

  assign o_ready = (state_q != StTwo);
  assign o_valid = (state_q != StEmpty);
  assign accept  = i_valid & o_ready;
  assign fire    = o_valid & i_ready;

  always_comb begin
    state_d        = state_q;
    head_load      = 1'b0;
    head_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (i_flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d   = StOne;
            head_load = 1'b1;
          end
        end
        StOne: begin
          if (accept && !fire) begin
            state_d   = StTwo;
            skid_load = 1'b1;
          end else if (fire && !accept) begin
            state_d = StEmpty;
          end else if (accept && fire) begin
            head_load = 1'b1;
          end
        end
        StTwo: begin
          if (fire) begin
            state_d        = StOne;
            head_from_skid = 1'b1;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q    <= StEmpty;
      head_imm_q <= '0;
      head_src_q <= '0;
      head_err_q <= 1'b0;
      skid_imm_q <= '0;
      skid_src_q <= '0;
      skid_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (head_load) begin
        head_imm_q <= new_imm;
        head_src_q <= i_imm_src;
        head_err_q <= new_err;
      end else if (head_from_skid) begin
        head_imm_q <= skid_imm_q;
        head_src_q <= skid_src_q;
        head_err_q <= skid_err_q;
      end
      if (skid_load) begin
        skid_imm_q <= new_imm;
        skid_src_q <= i_imm_src;
        skid_err_q <= new_err;
      end
    end
  end

  // Outputs are zero whenever no entry is present, regardless of register contents.
  assign o_imm_ext = o_valid ? head_imm_q : '0;
  assign o_imm_src = o_valid ? head_src_q : '0;
  assign o_err     = o_valid ? head_err_q : 1'b0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: one RV32 and one RV64 instance share all inputs.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        arst;
  logic        i_flush, i_valid, i_ready;
  logic [31:0] i_instr;
  logic [2:0]  i_imm_src;

  logic        o_ready32, o_valid32, o_err32;
  logic [31:0] o_imm32;
  logic [2:0]  o_src32;
  logic        o_ready64, o_valid64, o_err64;
  logic [63:0] o_imm64;
  logic [2:0]  o_src64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .arst(arst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready32),
    .i_instr(i_instr), .i_imm_src(i_imm_src), .o_valid(o_valid32), .i_ready(i_ready),
    .o_imm_ext(o_imm32), .o_imm_src(o_src32), .o_err(o_err32)
  );

  imm_gen_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .arst(arst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready64),
    .i_instr(i_instr), .i_imm_src(i_imm_src), .o_valid(o_valid64), .i_ready(i_ready),
    .o_imm_ext(o_imm64), .o_imm_src(o_src64), .o_err(o_err64)
  );

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  src;
    logic [31:0] exp32;
    logic [63:0] exp64;
    logic        err;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [2:0] src);
    i_valid   = 1'b1;
    i_instr   = instr;
    i_imm_src = src;
  endtask

  task automatic chk_flags(input string name, input logic v, input logic r);
    chk({name, " valid32"}, 64'(o_valid32), 64'(v));
    chk({name, " valid64"}, 64'(o_valid64), 64'(v));
    chk({name, " ready32"}, 64'(o_ready32), 64'(r));
    chk({name, " ready64"}, 64'(o_ready64), 64'(r));
  endtask

  task automatic chk_head(input string name, input logic [31:0] e32, input logic [63:0] e64,
                          input logic [2:0] src, input logic err);
    chk({name, " imm32"}, 64'(o_imm32), 64'(e32));
    chk({name, " imm64"}, o_imm64, e64);
    chk({name, " src32"}, 64'(o_src32), 64'(src));
    chk({name, " src64"}, 64'(o_src64), 64'(src));
    chk({name, " err32"}, 64'(o_err32), 64'(err));
    chk({name, " err64"}, 64'(o_err64), 64'(err));
  endtask

  initial begin
    vecs[0]  = '{32'hFFF00093, 3'd0, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[1]  = '{32'hFE20AE23, 3'd1, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[2]  = '{32'hFE000EE3, 3'd2, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[3]  = '{32'hFF9FF06F, 3'd3, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 1'b0};
    vecs[4]  = '{32'h800000B7, 3'd4, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0};
    vecs[5]  = '{32'h03F09093, 3'd5, 32'h0000001F, 64'h000000000000003F, 1'b0};
    vecs[6]  = '{32'h000FD073, 3'd6, 32'h0000001F, 64'h000000000000001F, 1'b0};
    vecs[7]  = '{32'hFFFFFFFF, 3'd7, 32'h00000000, 64'h0000000000000000, 1'b1};
    vecs[8]  = '{32'h7FF00013, 3'd0, 32'h000007FF, 64'h00000000000007FF, 1'b0};
    vecs[9]  = '{32'h00A12223, 3'd1, 32'h00000004, 64'h0000000000000004, 1'b0};
    vecs[10] = '{32'h00000463, 3'd2, 32'h00000008, 64'h0000000000000008, 1'b0};

    arst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_instr = '0; i_imm_src = '0;
    #1;
    chk_flags("reset", 1'b0, 1'b1);
    chk_head("reset", 32'h0, 64'h0, 3'd0, 1'b0);
    #2 arst = 1'b0;

    // Back-to-back stream: every cycle accept+fire in ONE replaces the head.
    for (int i = 0; i < 11; i++) begin
      offer(vecs[i].instr, vecs[i].src);
      step();
      chk_flags($sformatf("vec%0d", i), 1'b1, 1'b1);
      chk_head($sformatf("vec%0d", i), vecs[i].exp32, vecs[i].exp64, vecs[i].src, vecs[i].err);
    end
    i_valid = 1'b0;
    step();
    chk_flags("drain", 1'b0, 1'b1);
    chk_head("drain", 32'h0, 64'h0, 3'd0, 1'b0);

    // Backpressure: two accepts fill the buffer, third offer is held off.
    i_ready = 1'b0;
    offer(vecs[8].instr, vecs[8].src);
    step();
    chk_flags("bp1", 1'b1, 1'b1);
    chk_head("bp1", vecs[8].exp32, vecs[8].exp64, vecs[8].src, 1'b0);
    offer(vecs[9].instr, vecs[9].src);
    step();
    chk_flags("bp2", 1'b1, 1'b0);
    chk_head("bp2", vecs[8].exp32, vecs[8].exp64, vecs[8].src, 1'b0);
    offer(vecs[10].instr, vecs[10].src);
    step();
    chk_flags("bp3", 1'b1, 1'b0);
    chk_head("bp3", vecs[8].exp32, vecs[8].exp64, vecs[8].src, 1'b0);
    i_ready = 1'b1;
    step();
    chk_flags("bp_drain1", 1'b1, 1'b1);
    chk_head("bp_drain1", vecs[9].exp32, vecs[9].exp64, vecs[9].src, 1'b0);
    step();
    chk_flags("bp_drain2", 1'b1, 1'b1);
    chk_head("bp_drain2", vecs[10].exp32, vecs[10].exp64, vecs[10].src, 1'b0);
    i_valid = 1'b0;
    step();
    chk_flags("bp_drain3", 1'b0, 1'b1);

    // Flush from TWO with an offered entry that must be dropped.
    i_ready = 1'b0;
    offer(vecs[0].instr, vecs[0].src);
    step();
    offer(vecs[1].instr, vecs[1].src);
    step();
    chk_flags("pre_flush", 1'b1, 1'b0);
    i_flush = 1'b1;
    offer(vecs[2].instr, vecs[2].src);
    step();
    chk_flags("flush", 1'b0, 1'b1);
    chk_head("flush", 32'h0, 64'h0, 3'd0, 1'b0);
    i_flush = 1'b0;
    i_valid = 1'b0;
    step();
    chk_flags("post_flush", 1'b0, 1'b1);

    // Asynchronous reset between clock edges.
    offer(vecs[4].instr, vecs[4].src);
    step();
    i_valid = 1'b0;
    chk_flags("pre_arst", 1'b1, 1'b1);
    #2 arst = 1'b1;
    #1;
    chk_flags("arst", 1'b0, 1'b1);
    chk_head("arst", 32'h0, 64'h0, 3'd0, 1'b0);
    #1 arst = 1'b0;
    i_ready = 1'b1;
    step();
    chk_flags("post_arst", 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
